// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM / pulse generator with one shared prescaler.
//
// Each channel owns period/duty shadow registers, a ctrl register
// ({one_shot, invert, enable}), active period/duty copies and a frame counter.
// Shadows are copied into the active registers at every frame boundary and on
// the enable 0->1 edge, so software updates never tear a frame.
//
// Ports:
//   SYSCLK       fabric clock, all state on the rising edge
//   NSYSRESET    synchronous active-low reset
//   wr_en        one-cycle register write strobe
//   wr_ch        target channel (values >= NUM_CH are ignored)
//   wr_addr      0 = period shadow, 1 = duty shadow, 2 = ctrl, 3 = reserved
//   wr_data      write data (ctrl uses bits [2:0])
//   prescale     shared tick divider, one tick every prescale+1 cycles
//   pwm_out      registered channel outputs
//   frame_start  one-cycle pulse per channel after each frame boundary
module pwm_bank #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int CNT_W      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  SYSCLK,
  input  logic                  NSYSRESET,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [1:0]            wr_addr,
  input  logic [CNT_W-1:0]      wr_data,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic [NUM_CH-1:0]     frame_start
);

  localparam logic [1:0] ADDR_PER  = 2'd0;
  localparam logic [1:0] ADDR_DUTY = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_s;

  logic [NUM_CH-1:0][CNT_W-1:0] per_sh_q, per_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] per_act_q, per_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][2:0]       ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]            pwm_q, pwm_d;
  logic [NUM_CH-1:0]            fs_q, fs_d;

  logic [NUM_CH-1:0] wr_per_s, wr_duty_s, wr_ctrl_s;
  logic [NUM_CH-1:0] bnd_s, rise_s, load_s, raw_s;

  // Shared prescaler: tick when count reaches prescale; an over-range count
  // (prescale lowered below it) wraps to 0 without a tick.
  always_comb begin
    tick_s = (presc_q == prescale);
    if (tick_s) begin
      presc_d = '0;
    end else if (presc_q > prescale) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESCALE_W'(1);
    end
  end

  // Write decode: one strobe per channel and register; reserved address and
  // out-of-range channels produce no strobe.
  always_comb begin
    wr_per_s  = '0;
    wr_duty_s = '0;
    wr_ctrl_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        case (wr_addr)
          ADDR_PER:  wr_per_s[i]  = 1'b1;
          ADDR_DUTY: wr_duty_s[i] = 1'b1;
          ADDR_CTRL: wr_ctrl_s[i] = 1'b1;
          default:   wr_per_s[i]  = 1'b0;
        endcase
      end else begin
        wr_per_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next state: shadows, active loads, ctrl, counter and outputs.
  always_comb begin
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    pwm_d      = '0;
    fs_d       = '0;
    bnd_s      = '0;
    rise_s     = '0;
    load_s     = '0;
    raw_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bnd_s[i]  = ctrl_q[i][0] && tick_s && (cnt_q[i] == per_act_q[i]);
      rise_s[i] = wr_ctrl_s[i] && wr_data[0] && !ctrl_q[i][0];
      load_s[i] = bnd_s[i] || rise_s[i];

      if (wr_per_s[i]) begin
        per_sh_d[i] = wr_data;
      end else begin
        per_sh_d[i] = per_sh_q[i];
      end
      if (wr_duty_s[i]) begin
        duty_sh_d[i] = wr_data;
      end else begin
        duty_sh_d[i] = duty_sh_q[i];
      end

      // A shadow write landing on a load cycle goes straight to the active copy.
      if (load_s[i]) begin
        per_act_d[i]  = wr_per_s[i]  ? wr_data : per_sh_q[i];
        duty_act_d[i] = wr_duty_s[i] ? wr_data : duty_sh_q[i];
      end else begin
        per_act_d[i]  = per_act_q[i];
        duty_act_d[i] = duty_act_q[i];
      end

      // Software ctrl write has priority over the one-shot self-disable.
      if (wr_ctrl_s[i]) begin
        ctrl_d[i] = wr_data[2:0];
      end else if (bnd_s[i] && ctrl_q[i][2]) begin
        ctrl_d[i] = {ctrl_q[i][2:1], 1'b0};
      end else begin
        ctrl_d[i] = ctrl_q[i];
      end

      if (!ctrl_q[i][0]) begin
        cnt_d[i] = '0;
      end else if (bnd_s[i]) begin
        cnt_d[i] = '0;
      end else if (tick_s) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      raw_s[i] = ctrl_q[i][0] && (cnt_q[i] < duty_act_q[i]);
      pwm_d[i] = raw_s[i] ^ ctrl_q[i][1];
      fs_d[i]  = bnd_s[i];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      presc_q    <= '0;
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      pwm_q      <= '0;
      fs_q       <= '0;
    end else begin
      presc_q    <= presc_d;
      per_sh_q   <= per_sh_d;
      duty_sh_q  <= duty_sh_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      pwm_q      <= pwm_d;
      fs_q       <= fs_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed bench for pwm_bank (NUM_CH=4) plus a NUM_CH=3
// instance that shares the inputs to show writes to a missing channel are dropped.
module tb_pwm_bank;

  logic        SYSCLK = 1'b0;
  logic        NSYSRESET = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic [7:0]  prescale = 8'd0;
  logic [3:0]  pwm_out, frame_start;
  logic [2:0]  pwm3, fs3;

  int total = 0;
  int bad = 0;

  pwm_bank #(.NUM_CH(4), .CH_W(2), .CNT_W(16), .PRESCALE_W(8)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .prescale(prescale),
    .pwm_out(pwm_out), .frame_start(frame_start)
  );

  pwm_bank #(.NUM_CH(3), .CH_W(2), .CNT_W(16), .PRESCALE_W(8)) dut3 (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .prescale(prescale),
    .pwm_out(pwm3), .frame_start(fs3)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic        en;
    logic [1:0]  ch;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [3:0]  exp_pwm;
    logic [3:0]  exp_fs;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic en, input logic [1:0] ch, input logic [1:0] addr,
                         input logic [15:0] data, input logic [3:0] ep, input logic [3:0] ef);
    vec_t v;
    v.en = en; v.ch = ch; v.addr = addr; v.data = data; v.exp_pwm = ep; v.exp_fs = ef;
    vecs.push_back(v);
  endtask

  // One write cycle; returns at the negedge after the sampling edge.
  task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_addr = addr; wr_data = data;
    @(negedge SYSCLK);
    wr_en = 1'b0;
  endtask

  // Reset for n cycles with junk writes; outputs must read 0 every cycle.
  task automatic rst_seq(input int n);
    NSYSRESET = 1'b0;
    for (int k = 0; k < n; k++) begin
      wr_en = k[0]; wr_ch = k[1:0]; wr_addr = 2'd2; wr_data = 16'h0007;
      @(negedge SYSCLK);
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_fs", int'(frame_start), 0);
    end
    wr_en = 1'b0;
    NSYSRESET = 1'b1;
  endtask

  // Run n cycles, count high samples and frame_start pulses of one channel;
  // optionally issue one write in cycle wi.
  task automatic run_cnt(input int ch, input int n, input int wi, input logic [1:0] wa,
                         input logic [15:0] wd, output int hi, output int fsn, output int fs_last);
    hi = 0; fsn = 0; fs_last = -1;
    for (int k = 0; k < n; k++) begin
      if (k == wi) begin
        wr_en = 1'b1; wr_ch = ch[1:0]; wr_addr = wa; wr_data = wd;
      end
      @(negedge SYSCLK);
      wr_en = 1'b0;
      if (pwm_out[ch]) hi++;
      if (frame_start[ch]) begin
        fsn++;
        fs_last = k;
      end
    end
  endtask

  task automatic wait_fs(input int ch, input int lim);
    int k;
    k = 0;
    while (k < lim && !frame_start[ch]) begin
      @(negedge SYSCLK);
      k++;
    end
    chk("wait_fs_timeout", int'(frame_start[ch]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, fsn, fl;

    // Reset/idle: writes during reset are ignored.
    rst_seq(10);
    for (int k = 0; k < 10; k++) begin
      @(negedge SYSCLK);
      chk("post_rst_pwm", int'(pwm_out), 0);
      chk("post_rst_fs", int'(frame_start), 0);
    end
    // Reserved address must not act as ctrl.
    wr(2'd0, 2'd3, 16'h0007);
    for (int k = 0; k < 4; k++) begin
      @(negedge SYSCLK);
      chk("reserved_addr", int'(pwm_out), 0);
    end

    // Basic PWM ch0: period 9, duty 3, prescale 0.
    add_vec(1'b1, 2'd0, 2'd0, 16'd9, 4'b0000, 4'b0000);
    add_vec(1'b1, 2'd0, 2'd1, 16'd3, 4'b0000, 4'b0000);
    add_vec(1'b1, 2'd0, 2'd2, 16'd1, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0001, 4'b0000);
    for (int k = 0; k < 6; k++) add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0000, 4'b0000);
    add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0000, 4'b0001);
    for (int k = 0; k < 3; k++) add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0001, 4'b0000);
    add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0000, 4'b0000);
    add_vec(1'b1, 2'd0, 2'd2, 16'd0, 4'b0000, 4'b0000);
    add_vec(1'b0, 2'd0, 2'd0, 16'd0, 4'b0000, 4'b0000);
    for (int v = 0; v < vecs.size(); v++) begin
      wr_en = vecs[v].en; wr_ch = vecs[v].ch; wr_addr = vecs[v].addr; wr_data = vecs[v].data;
      @(negedge SYSCLK);
      wr_en = 1'b0;
      if (pwm_out !== vecs[v].exp_pwm || frame_start !== vecs[v].exp_fs) begin
        bad++;
        $display("FAIL vec%0d: pwm=%b fs=%b expected pwm=%b fs=%b",
                 v, pwm_out, frame_start, vecs[v].exp_pwm, vecs[v].exp_fs);
      end
      total++;
    end

    // Double buffering ch1: period 9, duty 5 -> 8 -> 12 -> 0.
    rst_seq(2);
    wr(2'd1, 2'd0, 16'd9);
    wr(2'd1, 2'd1, 16'd5);
    wr(2'd1, 2'd2, 16'd1);
    run_cnt(1, 10, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("db_first_hi", hi, 5); chk("db_first_fs", fsn, 1); chk("db_first_fspos", fl, 9);
    run_cnt(1, 10, 3, 2'd1, 16'd8, hi, fsn, fl);
    chk("db_midwr_hi", hi, 5); chk("db_midwr_fspos", fl, 9);
    run_cnt(1, 10, 3, 2'd1, 16'd12, hi, fsn, fl);
    chk("db_duty8_hi", hi, 8); chk("db_duty8_fspos", fl, 9);
    run_cnt(1, 10, 3, 2'd1, 16'd0, hi, fsn, fl);
    chk("db_duty12_hi", hi, 10); chk("db_duty12_fs", fsn, 1);
    run_cnt(1, 10, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("db_duty0_hi", hi, 0); chk("db_duty0_fspos", fl, 9);

    // Inversion and prescaler ch2: prescale 3, period 4, duty 2 -> 20-cycle frame.
    rst_seq(2);
    prescale = 8'd3;
    wr(2'd2, 2'd0, 16'd4);
    wr(2'd2, 2'd1, 16'd2);
    wr(2'd2, 2'd2, 16'd3);
    wait_fs(2, 100);
    run_cnt(2, 20, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("inv_hi", hi, 12); chk("inv_fs", fsn, 1); chk("inv_fspos", fl, 19);
    wr(2'd2, 2'd2, 16'd2);
    run_cnt(2, 10, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("inv_idle_hi", hi, 10); chk("inv_idle_fs", fsn, 0);
    prescale = 8'd0;

    // One-shot ch3: period 4, duty 1; NUM_CH=3 instance must ignore ch3.
    rst_seq(2);
    wr(2'd3, 2'd0, 16'd4);
    wr(2'd3, 2'd1, 16'd1);
    wr(2'd3, 2'd2, 16'd5);
    @(negedge SYSCLK);
    chk("os_pulse", int'(pwm_out), 8);
    chk("nc3_pwm", int'(pwm3), 0);
    run_cnt(3, 11, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("os_hi_after", hi, 0); chk("os_fs", fsn, 1); chk("os_fspos", fl, 3);
    chk("os_enable_cleared", int'(dut.ctrl_q[3][0]), 0);
    chk("nc3_fs", int'(fs3), 0);

    // Boundary collision ch0: period write at wrap cycle is used next frame.
    rst_seq(2);
    wr(2'd0, 2'd0, 16'd4);
    wr(2'd0, 2'd1, 16'd2);
    wr(2'd0, 2'd2, 16'd1);
    run_cnt(0, 4, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("bc_pre_hi", hi, 2);
    wr(2'd0, 2'd0, 16'd7);
    chk("bc_wrap_fs", int'(frame_start[0]), 1);
    run_cnt(0, 8, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("bc_hi", hi, 2); chk("bc_fs", fsn, 1); chk("bc_fspos", fl, 7);
    @(negedge SYSCLK);
    chk("bc_running", int'(pwm_out[0]), 1);
    // Reset mid-frame: outputs clear at the next edge, no completion pulse.
    rst_seq(1);
    run_cnt(0, 12, -1, 2'd0, 16'd0, hi, fsn, fl);
    chk("midrst_hi", hi, 0); chk("midrst_fs", fsn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
